// File: rtl/counter_up_down_fnd.sv
// counter_up_down_fnd: 4-digit decimal up/down counter (0..MAX_COUNT) with a tick divider
// and a time-multiplexed common-anode 7-segment (FND) driver.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   mode     in   count direction, 0 = up, 1 = down (sampled on tick cycles)
//   fndCom   out  [3:0] digit enables, active-low, bit0 = ones .. bit3 = thousands
//   fndFont  out  [7:0] segments, active-low, {dp,g,f,e,d,c,b,a}
//
// Optional build macro: FND_LEADING_ZERO_BLANK_EN blanks leading zero digits (thousands,
// hundreds, tens); the ones digit always shows. Undefined: all four digits always show.
module counter_up_down_fnd #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  output logic [3:0] fndCom,
  output logic [7:0] fndFont
);

  localparam int unsigned TickDiv = CLK_FREQ / TICK_HZ;
  localparam int unsigned ScanDiv = CLK_FREQ / SCAN_HZ;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned ScanW   = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(ScanDiv - 1);
  localparam logic [13:0]      CountMax = 14'(MAX_COUNT);

  logic [TickW-1:0] tick_cnt_q;
  logic [ScanW-1:0] scan_cnt_q;
  logic [1:0]       digit_idx_q;
  logic [13:0]      count_q, count_d;
  logic             tick, scan_adv;

  assign tick     = (tick_cnt_q == TickLast);
  assign scan_adv = (scan_cnt_q == ScanLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      count_q     <= 14'd0;
    end else begin
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + TickW'(1);
      scan_cnt_q  <= scan_adv ? '0 : scan_cnt_q + ScanW'(1);
      if (scan_adv) digit_idx_q <= digit_idx_q + 2'd1;
      count_q     <= count_d;
    end
  end

  // mode only matters in the tick cycle, so a mid-period change cannot double-step.
  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (!mode) count_d = (count_q >= CountMax) ? 14'd0 : count_q + 14'd1;
      else       count_d = (count_q == 14'd0) ? CountMax : count_q - 14'd1;
    end
  end

  logic [3:0] d0, d1, d2, d3;
  assign d0 = 4'(count_q % 14'd10);
  assign d1 = 4'((count_q / 14'd10) % 14'd10);
  assign d2 = 4'((count_q / 14'd100) % 14'd10);
  assign d3 = 4'(count_q / 14'd1000);

  // blank[n] set means digit n is a leading zero to be suppressed.
  logic [3:1] blank;
`ifdef FND_LEADING_ZERO_BLANK_EN
  assign blank = {count_q < 14'd1000, count_q < 14'd100, count_q < 14'd10};
`else
  assign blank = 3'b000;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [3:0] digit_sel;
  logic       blank_sel;

  always_comb begin
    fndCom    = 4'b1110;
    digit_sel = d0;
    blank_sel = 1'b0;
    unique case (digit_idx_q)
      2'd0: begin fndCom = 4'b1110; digit_sel = d0; blank_sel = 1'b0;     end
      2'd1: begin fndCom = 4'b1101; digit_sel = d1; blank_sel = blank[1]; end
      2'd2: begin fndCom = 4'b1011; digit_sel = d2; blank_sel = blank[2]; end
      2'd3: begin fndCom = 4'b0111; digit_sel = d3; blank_sel = blank[3]; end
    endcase
    // 4'hF is outside the decimal table and decodes to an all-off pattern.
    fndFont = seg7(blank_sel ? 4'hF : digit_sel);
  end

endmodule

// File: tb/tb_counter_up_down_fnd.sv
module tb_counter_up_down_fnd;

  localparam int TickClks = 10;  // 100 / 10
  localparam int ScanClks = 2;   // 100 / 50
  localparam int MaxCount = 9999;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] fndCom;
  logic [7:0] fndFont;

  int checks = 0;
  int errors = 0;

  // Reference model state: clocks since reset release and the decimal count.
  int cyc    = 0;
  int mcount = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         pow10   [4]  = '{1, 10, 100, 1000};

  counter_up_down_fnd #(
    .CLK_FREQ (100),
    .TICK_HZ  (10),
    .SCAN_HZ  (50),
    .MAX_COUNT(MaxCount)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .fndCom (fndCom),
    .fndFont(fndFont)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag);
    int         idx;
    int         dig;
    logic [3:0] exp_com;
    logic [7:0] exp_font;
    idx      = (cyc / ScanClks) % 4;
    exp_com  = ~(4'b0001 << idx);
    dig      = (mcount / pow10[idx]) % 10;
    exp_font = seg_tab[dig];
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (idx > 0 && mcount < pow10[idx]) exp_font = 8'hFF;
`endif
    checks++;
    assert (fndCom === exp_com) else begin
      errors++;
      $error("FAIL %s fndCom got %b want %b (count %0d)", tag, fndCom, exp_com, mcount);
    end
    checks++;
    assert (fndFont === exp_font) else begin
      errors++;
      $error("FAIL %s fndFont got %h want %h (count %0d idx %0d)", tag, fndFont, exp_font,
             mcount, idx);
    end
    checks++;
    assert (int'(dut.count_q) === mcount) else begin
      errors++;
      $error("FAIL %s count got %0d want %0d", tag, dut.count_q, mcount);
    end
  endtask

  // Advance n clocks, updating the model at every tick edge; check after each edge.
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (cyc % TickClks == 0) begin
        if (mode == 1'b0) mcount = (mcount == MaxCount) ? 0 : mcount + 1;
        else              mcount = (mcount == 0) ? MaxCount : mcount - 1;
      end
      #1;
      check_out(tag);
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    cyc    = 0;
    mcount = 0;
    check_out(tag);
    checks++;
    assert (fndCom === 4'b1110 && fndFont === 8'hC0) else begin
      errors++;
      $error("FAIL %s reset outputs got %b/%h want 1110/c0", tag, fndCom, fndFont);
    end
    #2 rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    mode = 1'b0;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_hold");
    #2 rst = 1'b1;

    // First tick after one full period, then count 5 after 50 clocks.
    run(9, "pre_first_tick");
    run(1, "first_tick");
    checks++;
    assert (int'(dut.count_q) === 1) else begin
      errors++;
      $error("FAIL count_after_10 got %0d want 1", dut.count_q);
    end
    run(40, "count_to_5");
    checks++;
    assert (int'(dut.count_q) === 5) else begin
      errors++;
      $error("FAIL count_after_50 got %0d want 5", dut.count_q);
    end

    // Down from zero wraps to MAX_COUNT; every digit shows 9.
    async_reset("reset_before_down");
    mode = 1'b1;
    run(10, "down_wrap");
    for (int i = 0; i < 8; i++) begin
      run(1, "scan_9999");
      checks++;
      assert (fndFont === 8'h90) else begin
        errors++;
        $error("FAIL all_nines fndFont got %h want 90", fndFont);
      end
    end
    run(2, "to_tick");

    // Now at 9998 after this tick; switch up and wrap through 9999 to 0.
    mode = 1'b0;
    run(10, "up_9999");
    run(10, "up_wrap_0");
    checks++;
    assert (int'(dut.count_q) === 0) else begin
      errors++;
      $error("FAIL up_wrap got %0d want 0", dut.count_q);
    end

    // Count up to 7, then toggle direction five clocks before a tick.
    run(70, "to_7");
    run(5, "mid_period");
    mode = 1'b1;
    run(5, "down_to_6");
    checks++;
    assert (int'(dut.count_q) === 6) else begin
      errors++;
      $error("FAIL mode_switch_down got %0d want 6", dut.count_q);
    end
    mode = 1'b0;
    run(10, "up_to_7");
    checks++;
    assert (int'(dut.count_q) === 7) else begin
      errors++;
      $error("FAIL mode_switch_up got %0d want 7", dut.count_q);
    end

    // Randomised direction changes at random points within and across periods.
    for (int i = 0; i < 200; i++) begin
      run($urandom_range(1, 15), "random");
      mode = 1'($urandom);
    end

    // Reach 1234 and observe one full scan of its digits.
    async_reset("reset_before_1234");
    mode = 1'b0;
    run(1234 * TickClks, "to_1234");
    run(8, "scan_1234");

    // Count 37 (leading digits blanked when the feature is built in), then async reset.
    async_reset("reset_before_37");
    run(37 * TickClks, "to_37");
    run(8, "scan_37");
    async_reset("reset_at_37");
    run(TickClks, "resume_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
